// File: rtl/car_controller.sv
// car_controller: elevator car motion and door sequencer.
// Owns the current floor, the last travel direction and the door phase. It
// consumes the {go_up, go_down, open_door} request vector. Every interval is
// counted in clk380hz cycles by a single counter that clears on each state entry.
// Optional feature macro: CAR_DOOR_BTN_EN enables the in-car open/close buttons.
// Without the macro, open_btn and close_btn are still ports but have no effect.
// Floor count and encodings normally come from global.vh. The guarded defaults
// below keep this file self-contained when that header is absent.

`ifndef F_N
`define F_N 8
`endif
`ifndef RS_UP
`define RS_UP 4'd1
`endif
`ifndef RS_DOWN
`define RS_DOWN 4'd2
`endif
`ifndef DS_CLOSED
`define DS_CLOSED 4'd0
`endif
`ifndef DS_OPENING
`define DS_OPENING 4'd1
`endif
`ifndef DS_OPEN
`define DS_OPEN 4'd2
`endif
`ifndef DS_CLOSING
`define DS_CLOSING 4'd3
`endif

module car_controller #(
  parameter int MOVE_CYC  = 760,
  parameter int DOOR_CYC  = 190,
  parameter int DWELL_CYC = 1140
) (
  input  logic       clk380hz,
  input  logic       rst,            // synchronous, active low
  input  logic [2:0] req,            // {go_up, go_down, open_door}
  input  logic       open_btn,
  input  logic       close_btn,
  output logic [7:0] curr_floor,
  output logic [3:0] running_state,
  output logic [3:0] door_state,
  output logic [2:0] dbg_state_o     // raw FSM state for observation
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MOVING  = 3'd1,
    S_OPENING = 3'd2,
    S_OPEN    = 3'd3,
    S_CLOSING = 3'd4
  } state_e;

  localparam logic [15:0] MOVE_LAST  = 16'(MOVE_CYC - 1);
  localparam logic [15:0] DOOR_LAST  = 16'(DOOR_CYC - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYC - 1);
  localparam logic [7:0]  TOP_FLOOR  = 8'(`F_N - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  floor_q, floor_d;
  logic [3:0]  rs_q, rs_d;

  logic go_up, go_down, open_door;
  assign go_up     = req[2];
  assign go_down   = req[1];
  assign open_door = req[0];

`ifndef CAR_DOOR_BTN_EN
  // Buttons have no effect in this build.
  logic unused_btn;
  assign unused_btn = open_btn ^ close_btn;
`endif

  // State, counter, floor and direction registers with synchronous active-low reset.
  always_ff @(posedge clk380hz) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      floor_q <= '0;
      rs_q    <= `RS_UP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      floor_q <= floor_d;
      rs_q    <= rs_d;
    end
  end

  // Next-state logic. Any state change also clears the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    floor_d = floor_q;
    rs_d    = rs_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (open_door) begin
          state_d = S_OPENING;
        end else if (go_up && (floor_q < TOP_FLOOR)) begin
          state_d = S_MOVING;
          rs_d    = `RS_UP;
        end else if (go_down && (floor_q != 8'd0)) begin
          state_d = S_MOVING;
          rs_d    = `RS_DOWN;
        end
      end
      S_MOVING: begin
        if (cnt_q == MOVE_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          // Saturating step; direction was validated on entry.
          if (rs_q == `RS_UP) begin
            if (floor_q < TOP_FLOOR) floor_d = floor_q + 8'd1;
          end else begin
            if (floor_q != 8'd0) floor_d = floor_q - 8'd1;
          end
        end
      end
      S_OPENING: begin
        if (cnt_q == DOOR_LAST) begin
          state_d = S_OPEN;
          cnt_d   = '0;
        end
      end
      S_OPEN: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = S_CLOSING;
          cnt_d   = '0;
        end
`ifdef CAR_DOOR_BTN_EN
        // The open button wins over the close button and restarts the dwell.
        if (open_btn) begin
          state_d = S_OPEN;
          cnt_d   = '0;
        end else if (close_btn) begin
          state_d = S_CLOSING;
          cnt_d   = '0;
        end
`endif
      end
      S_CLOSING: begin
        if (open_door) begin
          state_d = S_OPENING;
          cnt_d   = '0;
`ifdef CAR_DOOR_BTN_EN
        end else if (open_btn) begin
          state_d = S_OPENING;
          cnt_d   = '0;
`endif
        end else if (cnt_q == DOOR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Door phase is decoded purely from the registered state.
  always_comb begin
    door_state = `DS_CLOSED;
    case (state_q)
      S_OPENING: door_state = `DS_OPENING;
      S_OPEN:    door_state = `DS_OPEN;
      S_CLOSING: door_state = `DS_CLOSING;
      default:   door_state = `DS_CLOSED;
    endcase
  end

  assign curr_floor    = floor_q;
  assign running_state = rs_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_car_controller.sv
// tb_car_controller: directed bench for car_controller with short timing.
// The settings are F_N=8, MOVE_CYC=4, DOOR_CYC=2 and DWELL_CYC=6.
// A per-cycle vector table covers the default behaviour. Hand-written
// sequences then cover the in-car buttons. Their expected values follow
// whether CAR_DOOR_BTN_EN is defined.

module tb_car_controller;

  localparam int MOVE_CYC  = 4;
  localparam int DOOR_CYC  = 2;
  localparam int DWELL_CYC = 6;

  localparam logic [3:0] U  = 4'd1;  // RS_UP
  localparam logic [3:0] D  = 4'd2;  // RS_DOWN
  localparam logic [3:0] C  = 4'd0;  // DS_CLOSED
  localparam logic [3:0] OG = 4'd1;  // DS_OPENING
  localparam logic [3:0] O  = 4'd2;  // DS_OPEN
  localparam logic [3:0] CL = 4'd3;  // DS_CLOSING

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] req = 3'b000;
  logic       open_btn = 1'b0;
  logic       close_btn = 1'b0;
  logic [7:0] curr_floor;
  logic [3:0] running_state;
  logic [3:0] door_state;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  car_controller #(
    .MOVE_CYC (MOVE_CYC),
    .DOOR_CYC (DOOR_CYC),
    .DWELL_CYC(DWELL_CYC)
  ) dut (
    .clk380hz     (clk),
    .rst          (rst),
    .req          (req),
    .open_btn     (open_btn),
    .close_btn    (close_btn),
    .curr_floor   (curr_floor),
    .running_state(running_state),
    .door_state   (door_state),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       ob;
    logic       cb;
    logic [7:0] fl;
    logic [3:0] rs;
    logic [3:0] ds;
  } vec_t;

  vec_t vecs[$];

  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void v(input logic r, input logic [2:0] q, input logic ob,
                            input logic cb, input logic [7:0] fl,
                            input logic [3:0] rs, input logic [3:0] ds);
    vec_t e;
    e.rst = r; e.req = q; e.ob = ob; e.cb = cb; e.fl = fl; e.rs = rs; e.ds = ds;
    vecs.push_back(e);
  endfunction

  function automatic void hold(input logic r, input logic [2:0] q, input int n,
                               input logic [7:0] fl, input logic [3:0] rs,
                               input logic [3:0] ds);
    for (int k = 0; k < n; k++) v(r, q, 1'b0, 1'b0, fl, rs, ds);
  endfunction

  // One floor of travel: decision edge plus three counting edges show the old
  // floor. The fourth edge after the decision shows the new floor.
  function automatic void move(input logic [2:0] q, input logic [7:0] from,
                               input logic [7:0] to, input logic [3:0] rs);
    hold(1'b1, q, 4, from, rs, C);
    v(1'b1, q, 1'b0, 1'b0, to, rs, C);
  endfunction

  // A full door cycle started by request q, which is dropped after one cycle.
  function automatic void door(input logic [2:0] q, input logic [7:0] fl,
                               input logic [3:0] rs);
    v(1'b1, q, 1'b0, 1'b0, fl, rs, OG);
    hold(1'b1, 3'b000, 1, fl, rs, OG);
    hold(1'b1, 3'b000, 6, fl, rs, O);
    hold(1'b1, 3'b000, 2, fl, rs, CL);
    v(1'b1, 3'b000, 1'b0, 1'b0, fl, rs, C);
  endfunction

  // ---------------- driver + scoreboard ----------------
  task automatic step(input logic r, input logic [2:0] q, input logic ob,
                      input logic cb, input logic [7:0] fl, input logic [3:0] rs,
                      input logic [3:0] ds, input string tag);
    logic [15:0] exp_v;
    logic [15:0] got_v;
    rst = r; req = q; open_btn = ob; close_btn = cb;
    exp_q.push_back({fl, rs, ds});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    got_v = {curr_floor, running_state, door_state};
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got floor=%0d rs=%0d ds=%0d, want floor=%0d rs=%0d ds=%0d",
               tag, curr_floor, running_state, door_state,
               exp_v[15:8], exp_v[7:4], exp_v[3:0]);
    end
  endtask

  // Shorthand for the button sequences at floor 0, moving up.
  task automatic bstep(input logic [2:0] q, input logic ob, input logic cb,
                       input logic [3:0] ds, input string tag);
    step(1'b1, q, ob, cb, 8'd0, U, ds, tag);
  endtask

  initial begin
    // Reset: held for two cycles, then released with no requests.
    hold(1'b0, 3'b000, 2, 8'd0, U, C);
    hold(1'b1, 3'b000, 2, 8'd0, U, C);
    // go_up held from floor 0. Each floor is a fresh IDLE decision.
    move(3'b100, 8'd0, 8'd1, U);
    move(3'b100, 8'd1, 8'd2, U);
    move(3'b100, 8'd2, 8'd3, U);
    // A full door cycle at floor 3.
    door(3'b001, 8'd3, U);
    hold(1'b1, 3'b000, 1, 8'd3, U, C);
    // Travel to the top floor. Further go_up is ignored there.
    move(3'b100, 8'd3, 8'd4, U);
    move(3'b100, 8'd4, 8'd5, U);
    move(3'b100, 8'd5, 8'd6, U);
    move(3'b100, 8'd6, 8'd7, U);
    hold(1'b1, 3'b100, 3, 8'd7, U, C);
    // go_down switches the direction.
    move(3'b010, 8'd7, 8'd6, D);
    // open_door during the first CLOSING cycle reopens the door.
    v(1'b1, 3'b001, 1'b0, 1'b0, 8'd6, D, OG);
    hold(1'b1, 3'b000, 1, 8'd6, D, OG);
    hold(1'b1, 3'b000, 6, 8'd6, D, O);
    hold(1'b1, 3'b000, 1, 8'd6, D, CL);
    v(1'b1, 3'b001, 1'b0, 1'b0, 8'd6, D, OG);
    hold(1'b1, 3'b000, 1, 8'd6, D, OG);
    hold(1'b1, 3'b000, 6, 8'd6, D, O);
    hold(1'b1, 3'b000, 2, 8'd6, D, CL);
    hold(1'b1, 3'b000, 1, 8'd6, D, C);
    // Priority: go_up beats go_down, and open_door beats both.
    move(3'b110, 8'd6, 8'd7, U);
    door(3'b111, 8'd7, U);
    // Travel down to floor 0. Further go_down is ignored and the direction holds.
    for (int f = 7; f > 0; f--) move(3'b010, 8'(f), 8'(f - 1), D);
    hold(1'b1, 3'b010, 3, 8'd0, D, C);
    // Reset in the middle of a downward move discards it.
    move(3'b100, 8'd0, 8'd1, U);
    hold(1'b1, 3'b010, 2, 8'd1, D, C);
    hold(1'b0, 3'b010, 1, 8'd0, U, C);
    hold(1'b1, 3'b000, 2, 8'd0, U, C);
    // Reset while the door is open closes it at once.
    v(1'b1, 3'b001, 1'b0, 1'b0, 8'd0, U, OG);
    hold(1'b1, 3'b000, 1, 8'd0, U, OG);
    hold(1'b1, 3'b000, 1, 8'd0, U, O);
    hold(1'b0, 3'b000, 1, 8'd0, U, C);
    hold(1'b1, 3'b000, 3, 8'd0, U, C);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].ob, vecs[i].cb,
           vecs[i].fl, vecs[i].rs, vecs[i].ds, $sformatf("vec%0d", i));
    end

    // A: open_btn in OPEN cycle 5.
    bstep(3'b001, 1'b0, 1'b0, OG, "a_og0");
    bstep(3'b000, 1'b0, 1'b0, OG, "a_og1");
    bstep(3'b000, 1'b0, 1'b0, O, "a_open0");
    for (int k = 0; k < 4; k++) bstep(3'b000, 1'b0, 1'b0, O, "a_dwell");
    bstep(3'b000, 1'b1, 1'b0, O, "a_btn");
`ifdef CAR_DOOR_BTN_EN
    for (int k = 0; k < 5; k++) bstep(3'b000, 1'b0, 1'b0, O, "a_restart");
`endif
    bstep(3'b000, 1'b0, 1'b0, CL, "a_cl0");
    bstep(3'b000, 1'b0, 1'b0, CL, "a_cl1");
    bstep(3'b000, 1'b0, 1'b0, C, "a_closed");

    // B: close_btn in OPEN cycle 1.
    bstep(3'b001, 1'b0, 1'b0, OG, "b_og0");
    bstep(3'b000, 1'b0, 1'b0, OG, "b_og1");
    bstep(3'b000, 1'b0, 1'b0, O, "b_open0");
`ifdef CAR_DOOR_BTN_EN
    bstep(3'b000, 1'b0, 1'b1, CL, "b_btn");
    bstep(3'b000, 1'b0, 1'b0, CL, "b_cl1");
`else
    bstep(3'b000, 1'b0, 1'b1, O, "b_btn");
    for (int k = 0; k < 4; k++) bstep(3'b000, 1'b0, 1'b0, O, "b_dwell");
    bstep(3'b000, 1'b0, 1'b0, CL, "b_cl0");
    bstep(3'b000, 1'b0, 1'b0, CL, "b_cl1");
`endif
    bstep(3'b000, 1'b0, 1'b0, C, "b_closed");

    // C: open_btn in the first CLOSING cycle.
    bstep(3'b001, 1'b0, 1'b0, OG, "c_og0");
    bstep(3'b000, 1'b0, 1'b0, OG, "c_og1");
    for (int k = 0; k < 6; k++) bstep(3'b000, 1'b0, 1'b0, O, "c_dwell");
    bstep(3'b000, 1'b0, 1'b0, CL, "c_cl0");
`ifdef CAR_DOOR_BTN_EN
    bstep(3'b000, 1'b1, 1'b0, OG, "c_btn");
    bstep(3'b000, 1'b0, 1'b0, OG, "c_og1b");
    for (int k = 0; k < 6; k++) bstep(3'b000, 1'b0, 1'b0, O, "c_dwell2");
    bstep(3'b000, 1'b0, 1'b0, CL, "c_cl0b");
    bstep(3'b000, 1'b0, 1'b0, CL, "c_cl1b");
`else
    bstep(3'b000, 1'b1, 1'b0, CL, "c_btn");
`endif
    bstep(3'b000, 1'b0, 1'b0, C, "c_closed");

    // D: both buttons in OPEN cycle 3. The open button wins.
    bstep(3'b001, 1'b0, 1'b0, OG, "d_og0");
    bstep(3'b000, 1'b0, 1'b0, OG, "d_og1");
    bstep(3'b000, 1'b0, 1'b0, O, "d_open0");
    bstep(3'b000, 1'b0, 1'b0, O, "d_open1");
    bstep(3'b000, 1'b0, 1'b0, O, "d_open2");
    bstep(3'b000, 1'b1, 1'b1, O, "d_both");
`ifdef CAR_DOOR_BTN_EN
    for (int k = 0; k < 5; k++) bstep(3'b000, 1'b0, 1'b0, O, "d_restart");
`else
    for (int k = 0; k < 2; k++) bstep(3'b000, 1'b0, 1'b0, O, "d_dwell");
`endif
    bstep(3'b000, 1'b0, 1'b0, CL, "d_cl0");
    bstep(3'b000, 1'b0, 1'b0, CL, "d_cl1");
    bstep(3'b000, 1'b0, 1'b0, C, "d_closed");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
